// File: rtl/logic_unit_fifo_pkg.sv
// Shared opcode definitions for the bitwise logic unit and its result FIFO.
package logic_unit_fifo_pkg;

    localparam int LU_OP_W = 3;

    typedef logic [LU_OP_W-1:0] lu_op_t;

    localparam lu_op_t LU_AND  = 3'd0;
    localparam lu_op_t LU_OR   = 3'd1;
    localparam lu_op_t LU_NOR  = 3'd2;
    localparam lu_op_t LU_INV  = 3'd3;
    localparam lu_op_t LU_XOR  = 3'd4;
    localparam lu_op_t LU_NAND = 3'd5;
    localparam lu_op_t LU_XNOR = 3'd6;
    localparam lu_op_t LU_PASS = 3'd7;

endpackage

// File: rtl/logic_unit_core.sv
// Combinational WIDTH-bit bitwise operation selected by a 3-bit opcode.
module logic_unit_core
    import logic_unit_fifo_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  lu_op_t           op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            LU_AND:  y = a & b;
            LU_OR:   y = a | b;
            LU_NOR:  y = ~(a | b);
            LU_INV:  y = ~a;
            LU_XOR:  y = a ^ b;
            LU_NAND: y = ~(a & b);
            LU_XNOR: y = ~(a ^ b);
            LU_PASS: y = a;
        endcase
    end

endmodule

// File: rtl/logic_unit_fifo.sv
// Opcode-selected bitwise logic unit feeding a DEPTH-entry result FIFO.
// Define LOGIC_UNIT_FIFO_FLAGS_EN to add per-entry OUT_ZERO / OUT_ONES flags.
module logic_unit_fifo
    import logic_unit_fifo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     IN_VALID,
    output logic                     IN_READY,
    input  logic [LU_OP_W-1:0]       IN_OP,
    input  logic [WIDTH-1:0]         IN_A,
    input  logic [WIDTH-1:0]         IN_B,
    output logic                     OUT_VALID,
    input  logic                     OUT_READY,
    output logic [WIDTH-1:0]         OUT_Y,
    output logic [$clog2(DEPTH):0]   COUNT
`ifdef LOGIC_UNIT_FIFO_FLAGS_EN
    ,
    output logic                     OUT_ZERO,
    output logic                     OUT_ONES
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] result;
    logic             push;
    logic             pop;

    logic_unit_core #(.WIDTH(WIDTH)) u_core (
        .op (IN_OP),
        .a  (IN_A),
        .b  (IN_B),
        .y  (result)
    );

    // Ready/valid come only from registered occupancy, so no IN->OUT comb path.
    assign IN_READY  = (count != FULL_CNT);
    assign OUT_VALID = (count != '0);
    assign push      = IN_VALID & IN_READY;
    assign pop       = OUT_VALID & OUT_READY;
    assign OUT_Y     = mem[rd_ptr];
    assign COUNT     = count;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= result;
                wr_ptr      <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef LOGIC_UNIT_FIFO_FLAGS_EN
    logic [DEPTH-1:0] zero_q;
    logic [DEPTH-1:0] ones_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            zero_q <= '0;
            ones_q <= '0;
        end else if (push) begin
            zero_q[wr_ptr] <= (result == '0);
            ones_q[wr_ptr] <= (result == '1);
        end
    end

    assign OUT_ZERO = zero_q[rd_ptr];
    assign OUT_ONES = ones_q[rd_ptr];
`endif

endmodule

// File: tb/tb_logic_unit_fifo.sv
// Self-checking bench for logic_unit_fifo: table vectors plus a scoreboard queue.
module tb_logic_unit_fifo;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic                   CLK;
    logic                   RST;
    logic                   IN_VALID;
    logic                   IN_READY;
    logic [2:0]             IN_OP;
    logic [WIDTH-1:0]       IN_A;
    logic [WIDTH-1:0]       IN_B;
    logic                   OUT_VALID;
    logic                   OUT_READY;
    logic [WIDTH-1:0]       OUT_Y;
    logic [$clog2(DEPTH):0] COUNT;
`ifdef LOGIC_UNIT_FIFO_FLAGS_EN
    logic                   OUT_ZERO;
    logic                   OUT_ONES;
`endif

    logic_unit_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .IN_OP     (IN_OP),
        .IN_A      (IN_A),
        .IN_B      (IN_B),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .OUT_Y     (OUT_Y),
        .COUNT     (COUNT)
`ifdef LOGIC_UNIT_FIFO_FLAGS_EN
        ,
        .OUT_ZERO  (OUT_ZERO),
        .OUT_ONES  (OUT_ONES)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
    } vec_t;

    typedef struct {
        logic [31:0] y;
        logic        z;
        logic        o;
    } sb_t;

    vec_t vecs [9];
    sb_t  sb_q [$];
    int   total = 0;
    int   bad   = 0;

    function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return ~(a | b);
            3'd3:    return ~a;
            3'd4:    return a ^ b;
            3'd5:    return ~(a & b);
            3'd6:    return ~(a ^ b);
            default: return a;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // One cycle: drive at negedge, check against the model, then predict the edge.
    task automatic step(input logic v, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic ord, input logic [31:0] exp_y);
        int  sz;
        sb_t e;
        @(negedge CLK);
        IN_VALID  = v;
        IN_OP     = op;
        IN_A      = a;
        IN_B      = b;
        OUT_READY = ord;
        #1;
        sz = sb_q.size();
        chk("count", 32'(COUNT), 32'(sz));
        chk("in_ready", 32'(IN_READY), 32'(sz != DEPTH));
        chk("out_valid", 32'(OUT_VALID), 32'(sz != 0));
        if (sz != 0 && ord) begin
            e = sb_q.pop_front();
            chk("out_y", OUT_Y, e.y);
`ifdef LOGIC_UNIT_FIFO_FLAGS_EN
            chk("out_zero", 32'(OUT_ZERO), 32'(e.z));
            chk("out_ones", 32'(OUT_ONES), 32'(e.o));
`endif
        end
        if (v && sz != DEPTH) begin
            e.y = exp_y;
            e.z = (exp_y == 32'h0);
            e.o = (exp_y == 32'hFFFF_FFFF);
            sb_q.push_back(e);
        end
    endtask

    task automatic idle(input logic ord);
        step(1'b0, 3'd0, 32'h0, 32'h0, ord, 32'h0);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        vecs[0] = '{3'd2, 32'd27,         32'd13,         32'hFFFF_FFE0};
        vecs[1] = '{3'd0, 32'd26,         32'd19,         32'h0000_0012};
        vecs[2] = '{3'd3, 32'hFFFF_FFFF,  32'h1234_5678,  32'h0000_0000};
        vecs[3] = '{3'd1, 32'hFFFF_FFFF,  32'h0000_FFFF,  32'hFFFF_FFFF};
        vecs[4] = '{3'd4, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'h0FF0_0FF0};
        vecs[5] = '{3'd5, 32'hFFFF_0000,  32'h0F0F_0F0F,  32'hF0F0_FFFF};
        vecs[6] = '{3'd6, 32'h0000_FFFF,  32'h00FF_00FF,  32'hFF00_00FF};
        vecs[7] = '{3'd7, 32'hCAFE_BABE,  32'h1111_1111,  32'hCAFE_BABE};
        vecs[8] = '{3'd0, 32'h0000_0001,  32'h0000_0001,  32'h0000_0001};

        RST = 1'b0;
        IN_VALID = 1'b0;
        IN_OP = 3'd0;
        IN_A = '0;
        IN_B = '0;
        OUT_READY = 1'b0;
        #12;
        chk("rst_count", 32'(COUNT), 32'd0);
        chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
        chk("rst_in_ready", 32'(IN_READY), 32'd1);
        chk("rst_out_y", OUT_Y, 32'h0);
        @(negedge CLK);
        RST = 1'b1;

        // Single ops, each drained one cycle after its push.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 1'b1, vecs[i].y);
            idle(1'b1);
        end

        // Fill with consumer stalled, try a fifth beat, then drain in order.
        for (int i = 4; i < 9; i++) begin
            step(1'b1, vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, vecs[i].y);
        end
        step(1'b1, vecs[8].op, vecs[8].a, vecs[8].b, 1'b0, vecs[8].y);
        for (int i = 0; i < 5; i++) idle(1'b1);

        // Hold occupancy at 2 with simultaneous push/pop across pointer wrap.
        for (int i = 0; i < 2; i++) begin
            ra = $urandom;
            rb = $urandom;
            step(1'b1, 3'd4, ra, rb, 1'b0, ref_op(3'd4, ra, rb));
        end
        for (int i = 0; i < 10; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            step(1'b1, rop, ra, rb, 1'b1, ref_op(rop, ra, rb));
        end
        for (int i = 0; i < 3; i++) idle(1'b1);

        // Reset with three entries buffered: state clears without a clock edge.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 3'd1, 32'(i), 32'h100, 1'b0, ref_op(3'd1, 32'(i), 32'h100));
        end
        @(negedge CLK);
        IN_VALID = 1'b0;
        #1;
        RST = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(OUT_VALID), 32'd0);
        chk("midrst_count", 32'(COUNT), 32'd0);
        sb_q.delete();
        @(negedge CLK);
        RST = 1'b1;
        step(1'b1, 3'd7, 32'h1234_5678, 32'hDEAD_BEEF, 1'b1, 32'h1234_5678);
        idle(1'b1);

`ifdef LOGIC_UNIT_FIFO_FLAGS_EN
        step(1'b1, 3'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'h0);
        step(1'b1, 3'd6, 32'd5, 32'd5, 1'b1, 32'hFFFF_FFFF);
        idle(1'b1);
        idle(1'b1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
